instr_fetch_unit: RTL and testbench

- Instruction fetch stage between the program ROM and the control unit.
- Drives the 16-bit address bus and reads opcode and operand bytes one per enabled cycle.
- Sizes each instruction from its opcode (6502 addressing-mode rules) and presents a complete instruction (opcode + up to 2 operand bytes + its PC) to the control unit over a valid/ready handshake.
- Accepts PC redirects for branches and jumps.

---
 rtl/instr_fetch_unit_pkg.sv | 17 +
 rtl/instr_fetch_unit_if.sv | 35 +++
 rtl/instr_fetch_unit_decoder.sv | 46 ++++
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH_OP = 2'd0,
      FETCH_LO = 2'd1,
      FETCH_HI = 2'd2,
      HOLD     = 2'd3
   } state_e;

   localparam logic [1:0]  LEN1 = 2'd1;
   localparam logic [1:0]  LEN2 = 2'd2;
   localparam logic [1:0]  LEN3 = 2'd3;

   localparam logic [15:0] RESET_PC_DEF = 16'h0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ROM bus, instruction handshake and redirect signals of the fetch stage.
interface instr_fetch_if;

   logic [15:0] addr_bus_out;
   logic        mem_read;
   logic [7:0]  data_bus_in;

   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  instr_opcode;
   logic [15:0] instr_operand;
   logic [1:0]  instr_len;
   logic [15:0] instr_pc;
   logic        instr_illegal;

   logic        redirect_valid;
   logic [15:0] redirect_pc;

   modport master (
      output addr_bus_out, mem_read,
      input  data_bus_in,
      output instr_valid, instr_opcode, instr_operand, instr_len, instr_pc, instr_illegal,
      input  instr_ready,
      input  redirect_valid, redirect_pc
   );

   modport slave (
      input  addr_bus_out, mem_read,
      output data_bus_in,
      input  instr_valid, instr_opcode, instr_operand, instr_len, instr_pc, instr_illegal,
      output instr_ready,
      output redirect_valid, redirect_pc
   );

endinterface

// File: rtl/instr_fetch_unit_decoder.sv
// Instruction length from the opcode using 6502 addressing-mode groups (cc / bbb fields).
module opcode_length_decoder
   import fetch_pkg::*;
(
   input  logic [7:0] opcode_i,
   output logic [1:0] len_o,
   output logic       illegal_o
);

   logic [1:0] cc;
   logic [2:0] bbb;

   assign cc  = opcode_i[1:0];
   assign bbb = opcode_i[4:2];

   always_comb begin
      len_o     = LEN2;
      illegal_o = 1'b0;
      case (cc)
         2'b00, 2'b10: begin
            case (bbb)
               3'b010, 3'b110: len_o = LEN1;
               3'b011, 3'b111: len_o = LEN3;
               default:        len_o = LEN2;
            endcase
         end
         2'b01: begin
            case (bbb)
               3'b011, 3'b110, 3'b111: len_o = LEN3;
               default:                len_o = LEN2;
            endcase
         end
         default: begin
            len_o     = LEN1;
            illegal_o = 1'b1;
         end
      endcase
      // BRK/RTI/RTS/JSR break the group pattern
      case (opcode_i)
         8'h00, 8'h40, 8'h60: len_o = LEN1;
         8'h20:               len_o = LEN3;
         default:             ;
      endcase
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: walks the ROM one byte per enabled cycle and holds a full instruction for the control unit.
//
//  state    | meaning
//  FETCH_OP | reading opcode byte at pc
//  FETCH_LO | reading first operand byte
//  FETCH_HI | reading second operand byte
//  HOLD     | instruction complete, waiting for instr_ready
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC = RESET_PC_DEF
)(
   input  logic          clk_in,
   input  logic          reset,
   input  logic          clk_en,
   instr_fetch_if.master bus
);

   state_e      state_q;
   logic [15:0] pc_q;
   logic [15:0] instr_pc_q;
   logic [15:0] operand_q;
   logic [7:0]  opcode_q;
   logic [1:0]  len_q;
   logic        valid_q;
   logic        mem_read_q;
   logic        illegal_q;

   logic [1:0]  dec_len;
   logic        dec_illegal;
   logic [15:0] pc_inc_d;

   opcode_length_decoder u_dec (
      .opcode_i  (bus.data_bus_in),
      .len_o     (dec_len),
      .illegal_o (dec_illegal)
   );

   assign pc_inc_d = pc_q + 16'd1;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q    <= FETCH_OP;
         pc_q       <= RESET_PC;
         instr_pc_q <= '0;
         operand_q  <= '0;
         opcode_q   <= '0;
         len_q      <= '0;
         valid_q    <= 1'b0;
         mem_read_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else if (clk_en) begin
         // A redirect also completes any transfer in HOLD: valid simply drops.
         if (bus.redirect_valid) begin
            pc_q       <= bus.redirect_pc;
            state_q    <= FETCH_OP;
            valid_q    <= 1'b0;
            mem_read_q <= 1'b1;
         end else begin
            case (state_q)
               FETCH_OP: begin
                  opcode_q   <= bus.data_bus_in;
                  instr_pc_q <= pc_q;
                  pc_q       <= pc_inc_d;
                  operand_q  <= '0;
                  len_q      <= dec_len;
                  illegal_q  <= dec_illegal;
                  if (dec_len == LEN1) begin
                     state_q    <= HOLD;
                     valid_q    <= 1'b1;
                     mem_read_q <= 1'b0;
                  end else begin
                     state_q    <= FETCH_LO;
                     mem_read_q <= 1'b1;
                  end
               end
               FETCH_LO: begin
                  operand_q[7:0] <= bus.data_bus_in;
                  pc_q           <= pc_inc_d;
                  if (len_q == LEN2) begin
                     state_q    <= HOLD;
                     valid_q    <= 1'b1;
                     mem_read_q <= 1'b0;
                  end else begin
                     state_q    <= FETCH_HI;
                     mem_read_q <= 1'b1;
                  end
               end
               FETCH_HI: begin
                  operand_q[15:8] <= bus.data_bus_in;
                  pc_q            <= pc_inc_d;
                  state_q         <= HOLD;
                  valid_q         <= 1'b1;
                  mem_read_q      <= 1'b0;
               end
               HOLD: begin
                  if (valid_q && bus.instr_ready) begin
                     state_q    <= FETCH_OP;
                     valid_q    <= 1'b0;
                     mem_read_q <= 1'b1;
                  end
               end
               default: begin
                  state_q <= FETCH_OP;
               end
            endcase
         end
      end
   end

   assign bus.addr_bus_out  = pc_q;
   assign bus.mem_read      = mem_read_q;
   assign bus.instr_valid   = valid_q;
   assign bus.instr_opcode  = opcode_q;
   assign bus.instr_operand = operand_q;
   assign bus.instr_len     = len_q;
   assign bus.instr_pc      = instr_pc_q;
   assign bus.instr_illegal = illegal_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one DUT at the default reset PC, one at FFFF for the wrap case.
module tb_instr_fetch_unit;

   logic clk_in = 1'b0;
   logic reset_a, clk_en_a;
   logic reset_b, clk_en_b;

   logic [7:0] rom_a [0:65535];
   logic [7:0] rom_b [0:65535];

   int n_vec = 0;
   int n_err = 0;

   instr_fetch_if bus_a ();
   instr_fetch_if bus_b ();

   assign bus_a.data_bus_in = rom_a[bus_a.addr_bus_out];
   assign bus_b.data_bus_in = rom_b[bus_b.addr_bus_out];

   instr_fetch_unit u_dut_a (
      .clk_in (clk_in),
      .reset  (reset_a),
      .clk_en (clk_en_a),
      .bus    (bus_a)
   );

   instr_fetch_unit #(.RESET_PC(16'hFFFF)) u_dut_b (
      .clk_in (clk_in),
      .reset  (reset_b),
      .clk_en (clk_en_b),
      .bus    (bus_b)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, " valid"},    16'(bus_a.instr_valid),   16'h0);
      chk({tag, " mem_read"}, 16'(bus_a.mem_read),      16'h0);
      chk({tag, " illegal"},  16'(bus_a.instr_illegal), 16'h0);
      chk({tag, " opcode"},   16'(bus_a.instr_opcode),  16'h0);
      chk({tag, " operand"},  bus_a.instr_operand,      16'h0);
      chk({tag, " len"},      16'(bus_a.instr_len),     16'h0);
      chk({tag, " pc"},       bus_a.instr_pc,           16'h0);
      chk({tag, " addr"},     bus_a.addr_bus_out,       16'h0000);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         rom_a[i] = 8'h00;
         rom_b[i] = 8'h00;
      end
      rom_a[16'h0000] = 8'hA0; rom_a[16'h0001] = 8'hFF;
      rom_a[16'h0002] = 8'h4C; rom_a[16'h0003] = 8'h34; rom_a[16'h0004] = 8'h12;
      rom_a[16'h0005] = 8'hEA;
      rom_a[16'h0006] = 8'hE8;
      rom_a[16'h0007] = 8'h20; rom_a[16'h0008] = 8'h00; rom_a[16'h0009] = 8'h30;
      rom_a[16'h0010] = 8'h03;
      rom_a[16'h0011] = 8'hAD; rom_a[16'h0012] = 8'h56; rom_a[16'h0013] = 8'h34;
      rom_b[16'hFFFF] = 8'hAD; rom_b[16'h0000] = 8'h00; rom_b[16'h0001] = 8'h20;

      reset_a = 1'b1; clk_en_a = 1'b1;
      reset_b = 1'b1; clk_en_b = 1'b1;
      bus_a.instr_ready = 1'b0; bus_a.redirect_valid = 1'b0; bus_a.redirect_pc = 16'h0000;
      bus_b.instr_ready = 1'b0; bus_b.redirect_valid = 1'b0; bus_b.redirect_pc = 16'h0000;

      tick(2);
      chk_reset_a("reset");

      // 2-byte LDY #$FF
      reset_a = 1'b0; bus_a.instr_ready = 1'b1;
      tick(1);
      chk("ldy mid valid", 16'(bus_a.instr_valid), 16'h0);
      chk("ldy mid addr",  bus_a.addr_bus_out,     16'h0001);
      chk("ldy mid rd",    16'(bus_a.mem_read),    16'h1);
      tick(1);
      chk("ldy valid",   16'(bus_a.instr_valid),  16'h1);
      chk("ldy opcode",  16'(bus_a.instr_opcode), 16'h00A0);
      chk("ldy operand", bus_a.instr_operand,     16'h00FF);
      chk("ldy len",     16'(bus_a.instr_len),    16'h2);
      chk("ldy pc",      bus_a.instr_pc,          16'h0000);
      chk("ldy addr",    bus_a.addr_bus_out,      16'h0002);
      chk("ldy rd",      16'(bus_a.mem_read),     16'h0);
      tick(1);
      chk("bubble valid", 16'(bus_a.instr_valid), 16'h0);
      chk("bubble addr",  bus_a.addr_bus_out,     16'h0002);

      // 3-byte JMP $1234
      tick(3);
      chk("jmp valid",   16'(bus_a.instr_valid),  16'h1);
      chk("jmp opcode",  16'(bus_a.instr_opcode), 16'h004C);
      chk("jmp operand", bus_a.instr_operand,     16'h1234);
      chk("jmp len",     16'(bus_a.instr_len),    16'h3);
      chk("jmp pc",      bus_a.instr_pc,          16'h0002);
      chk("jmp addr",    bus_a.addr_bus_out,      16'h0005);

      // 1-byte NOP
      tick(2);
      chk("nop valid",   16'(bus_a.instr_valid),  16'h1);
      chk("nop opcode",  16'(bus_a.instr_opcode), 16'h00EA);
      chk("nop operand", bus_a.instr_operand,     16'h0000);
      chk("nop len",     16'(bus_a.instr_len),    16'h1);
      chk("nop pc",      bus_a.instr_pc,          16'h0005);

      // INX held by back-pressure
      tick(2);
      bus_a.instr_ready = 1'b0;
      chk("inx opcode", 16'(bus_a.instr_opcode), 16'h00E8);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("stall valid",  16'(bus_a.instr_valid),  16'h1);
         chk("stall opcode", 16'(bus_a.instr_opcode), 16'h00E8);
         chk("stall pc",     bus_a.instr_pc,          16'h0006);
         chk("stall addr",   bus_a.addr_bus_out,      16'h0007);
      end
      bus_a.instr_ready = 1'b1;
      tick(1);
      chk("post stall valid", 16'(bus_a.instr_valid), 16'h0);
      chk("post stall addr",  bus_a.addr_bus_out,     16'h0007);
      chk("post stall rd",    16'(bus_a.mem_read),    16'h1);

      // JSR redirected during its FETCH_LO
      tick(1);
      chk("jsr lo addr", bus_a.addr_bus_out, 16'h0008);
      bus_a.redirect_valid = 1'b1; bus_a.redirect_pc = 16'h0010;
      tick(1);
      bus_a.redirect_valid = 1'b0;
      chk("redir valid", 16'(bus_a.instr_valid), 16'h0);
      chk("redir addr",  bus_a.addr_bus_out,     16'h0010);
      tick(1);
      chk("ill valid",   16'(bus_a.instr_valid),   16'h1);
      chk("ill opcode",  16'(bus_a.instr_opcode),  16'h0003);
      chk("ill flag",    16'(bus_a.instr_illegal), 16'h1);
      chk("ill len",     16'(bus_a.instr_len),     16'h1);
      chk("ill pc",      bus_a.instr_pc,           16'h0010);

      // Redirect coinciding with a transfer
      bus_a.redirect_valid = 1'b1; bus_a.redirect_pc = 16'h0011;
      tick(1);
      bus_a.redirect_valid = 1'b0;
      chk("xfer redir valid", 16'(bus_a.instr_valid), 16'h0);
      chk("xfer redir addr",  bus_a.addr_bus_out,     16'h0011);

      // Freeze mid-fetch, then reset with clk_en low
      tick(1);
      chk("lda lo addr", bus_a.addr_bus_out, 16'h0012);
      clk_en_a = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("frz addr",   bus_a.addr_bus_out,      16'h0012);
         chk("frz valid",  16'(bus_a.instr_valid),  16'h0);
         chk("frz opcode", 16'(bus_a.instr_opcode), 16'h00AD);
         chk("frz len",    16'(bus_a.instr_len),    16'h3);
         chk("frz ill",    16'(bus_a.instr_illegal), 16'h0);
      end
      reset_a = 1'b1;
      tick(1);
      chk_reset_a("frz reset");

      // Handshake cannot complete while disabled
      reset_a = 1'b0; clk_en_a = 1'b1;
      tick(2);
      chk("en valid", 16'(bus_a.instr_valid), 16'h1);
      clk_en_a = 1'b0;
      tick(3);
      chk("en hold valid", 16'(bus_a.instr_valid), 16'h1);
      chk("en hold addr",  bus_a.addr_bus_out,     16'h0002);
      clk_en_a = 1'b1;
      tick(1);
      chk("en xfer valid", 16'(bus_a.instr_valid), 16'h0);

      // PC wrap on the FFFF instance
      chk("wrap reset addr", bus_b.addr_bus_out, 16'hFFFF);
      reset_b = 1'b0;
      tick(1);
      chk("wrap lo addr", bus_b.addr_bus_out, 16'h0000);
      tick(2);
      chk("wrap valid",   16'(bus_b.instr_valid),  16'h1);
      chk("wrap opcode",  16'(bus_b.instr_opcode), 16'h00AD);
      chk("wrap operand", bus_b.instr_operand,     16'h2000);
      chk("wrap len",     16'(bus_b.instr_len),    16'h3);
      chk("wrap pc",      bus_b.instr_pc,          16'hFFFF);
      chk("wrap addr",    bus_b.addr_bus_out,      16'h0002);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
